// File: rtl/isp_pkg.sv
// Shared ISP definitions: pipeline latency of the 3x3 window generator,
// border-fill modes and the default-width pixel type.
package isp_pkg;

    // Cycles from an accepted input pixel to its window on the outputs.
    localparam int MATRIX_LAT = 2;

    // Pixel width used by the Y/greyscale path.
    localparam int PIX_W = 8;

    typedef logic [PIX_W-1:0] pix_t;

    // How window cells that fall outside the image are filled.
    typedef enum logic {
        BORDER_ZERO      = 1'b0,
        BORDER_REPLICATE = 1'b1
    } border_mode_e;

endpackage

// File: rtl/line_buf_ram.sv
// One-line pixel store: one write port, one read port with a registered
// output. A read of the address being written returns the old word.
// Contents are never reset.
module line_buf_ram #(
    parameter int DATA_W = 8,
    parameter int DEPTH  = 640,
    parameter int ADDR_W = 10
) (
    input  logic              sys_clk,
    input  logic              we,
    input  logic [ADDR_W-1:0] waddr,
    input  logic [DATA_W-1:0] wdata,
    input  logic              re,
    input  logic [ADDR_W-1:0] raddr,
    output logic [DATA_W-1:0] rdata
);

    logic [DATA_W-1:0] mem [0:DEPTH-1];

    // Write the new word and register the read word (read-before-write).
    always_ff @(posedge sys_clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
        if (re) begin
            rdata <= mem[raddr];
        end
    end

endmodule

// File: rtl/matrix3x3_gen_param.sv
// 3x3 sliding-window generator. Two cascaded line buffers supply the two
// previous lines; row/column tracking substitutes border cells so the
// first window of a frame is already well defined.
//
// Build option: MATRIX_BORDER_REPLICATE_EN
//   defined   - out-of-image cells copy the nearest in-image cell
//   undefined - out-of-image cells are zero
module matrix3x3_gen_param
    import isp_pkg::*;
#(
    parameter int DATA_W = 8,
    parameter int IMG_W  = 640,
    parameter int IMG_H  = 480,
    parameter int COL_W  = 12
) (
    input  logic              sys_clk,
    input  logic              sys_rst_n,
    input  logic              pre_vsync,
    input  logic              pre_href,
    input  logic              pre_de,
    input  logic [DATA_W-1:0] pre_data,
    output logic              matrix_vsync,
    output logic              matrix_href,
    output logic              matrix_de,
    output logic              matrix_win_ok,
    output logic [DATA_W-1:0] matrix_p11,
    output logic [DATA_W-1:0] matrix_p12,
    output logic [DATA_W-1:0] matrix_p13,
    output logic [DATA_W-1:0] matrix_p21,
    output logic [DATA_W-1:0] matrix_p22,
    output logic [DATA_W-1:0] matrix_p23,
    output logic [DATA_W-1:0] matrix_p31,
    output logic [DATA_W-1:0] matrix_p32,
    output logic [DATA_W-1:0] matrix_p33,
    output logic              line_ovf
);

    localparam int ADDR_W = (IMG_W > 1) ? $clog2(IMG_W) : 1;
    localparam logic [COL_W-1:0] COL_LIMIT = COL_W'(IMG_W);
    localparam logic [COL_W-1:0] ROW_LAST  = COL_W'(IMG_H - 1);
    localparam logic [COL_W-1:0] ONE       = COL_W'(1);

`ifdef MATRIX_BORDER_REPLICATE_EN
    localparam border_mode_e BORDER_MODE = BORDER_REPLICATE;
`else
    localparam border_mode_e BORDER_MODE = BORDER_ZERO;
`endif

    // Sideband delay lines; element 0 doubles as the edge-detect history.
    logic [MATRIX_LAT-1:0] vs_pipe;
    logic [MATRIX_LAT-1:0] hs_pipe;

    // Position of the next pixel within the frame.
    logic [COL_W-1:0] row;
    logic [COL_W-1:0] col;
    logic             line_any;
    // Pixels are ignored until a frame start has been seen since reset.
    logic             frame_act;

    logic             vs_rise;
    logic             hs_fall;
    logic [COL_W-1:0] cur_row;
    logic [COL_W-1:0] cur_col;
    logic             pix_in;
    logic             accept;
    logic             drop;

    // Stage 1: registered pixel, its position, and line-buffer reads.
    logic              s1_de;
    logic [DATA_W-1:0] s1_data;
    logic [COL_W-1:0]  s1_row;
    logic [COL_W-1:0]  s1_col;
    logic [DATA_W-1:0] rd0;
    logic [DATA_W-1:0] rd1;

    // Stage 2 inputs: the new window column after border substitution.
    logic [DATA_W-1:0] top_cell;
    logic [DATA_W-1:0] mid_cell;
    logic [DATA_W-1:0] bot_cell;
    logic [DATA_W-1:0] edge_top;
    logic [DATA_W-1:0] edge_mid;
    logic [DATA_W-1:0] edge_bot;
    logic              first_col;
    logic              win_inside;

    // Frame/line edge detection and the position of the pixel on the inputs.
    always_comb begin
        vs_rise = pre_vsync & ~vs_pipe[0];
        hs_fall = ~pre_href & hs_pipe[0];
        // A frame start overrides any position left from the previous frame.
        cur_row = vs_rise ? '0 : row;
        cur_col = vs_rise ? '0 : col;
        pix_in  = pre_de & (frame_act | vs_rise);
        accept  = pix_in & (cur_col < COL_LIMIT);
        drop    = pix_in & ~(cur_col < COL_LIMIT);
    end

    // Sideband delay lines, aligned with the window pipeline.
    always_ff @(posedge sys_clk) begin
        if (!sys_rst_n) begin
            vs_pipe <= '0;
            hs_pipe <= '0;
        end else begin
            vs_pipe <= {vs_pipe[MATRIX_LAT-2:0], pre_vsync};
            hs_pipe <= {hs_pipe[MATRIX_LAT-2:0], pre_href};
        end
    end

    assign matrix_vsync = vs_pipe[MATRIX_LAT-1];
    assign matrix_href  = hs_pipe[MATRIX_LAT-1];

    // Row/column tracking and the sticky overflow flag.
    always_ff @(posedge sys_clk) begin
        if (!sys_rst_n) begin
            row       <= '0;
            col       <= '0;
            line_any  <= 1'b0;
            frame_act <= 1'b0;
            line_ovf  <= 1'b0;
        end else if (vs_rise) begin
            frame_act <= 1'b1;
            row       <= '0;
            col       <= accept ? ONE : '0;
            line_any  <= accept;
            line_ovf  <= 1'b0;
        end else if (hs_fall) begin
            col      <= '0;
            line_any <= 1'b0;
            // Empty lines (href without any pixel) do not advance the row.
            if (line_any && (row != ROW_LAST)) begin
                row <= row + ONE;
            end
        end else if (accept) begin
            col      <= col + ONE;
            line_any <= 1'b1;
        end else if (drop) begin
            // col stays at IMG_W so every further pixel of the line drops.
            line_ovf <= 1'b1;
        end
    end

    // Stage 1 register: pixel, position and valid.
    always_ff @(posedge sys_clk) begin
        if (!sys_rst_n) begin
            s1_de   <= 1'b0;
            s1_data <= '0;
            s1_row  <= '0;
            s1_col  <= '0;
        end else begin
            s1_de <= accept;
            if (accept) begin
                s1_data <= pre_data;
                s1_row  <= cur_row;
                s1_col  <= cur_col;
            end
        end
    end

    // Line r-1: written with the incoming pixel, read at the same column.
    line_buf_ram #(
        .DATA_W (DATA_W),
        .DEPTH  (IMG_W),
        .ADDR_W (ADDR_W)
    ) u_line0 (
        .sys_clk (sys_clk),
        .we      (accept),
        .waddr   (cur_col[ADDR_W-1:0]),
        .wdata   (pre_data),
        .re      (accept),
        .raddr   (cur_col[ADDR_W-1:0]),
        .rdata   (rd0)
    );

    // Line r-2: fed one cycle later with the word just read out of line 0.
    line_buf_ram #(
        .DATA_W (DATA_W),
        .DEPTH  (IMG_W),
        .ADDR_W (ADDR_W)
    ) u_line1 (
        .sys_clk (sys_clk),
        .we      (s1_de),
        .waddr   (s1_col[ADDR_W-1:0]),
        .wdata   (rd0),
        .re      (accept),
        .raddr   (cur_col[ADDR_W-1:0]),
        .rdata   (rd1)
    );

    // Border substitution for missing rows, and the fill for missing columns.
    always_comb begin
        bot_cell = s1_data;
        mid_cell = '0;
        top_cell = '0;
        if (BORDER_MODE == BORDER_REPLICATE) begin
            // Missing lines take the nearest line that exists: row r, then row 0.
            mid_cell = (s1_row != '0) ? rd0 : s1_data;
            if (s1_row > ONE) begin
                top_cell = rd1;
            end else if (s1_row == ONE) begin
                top_cell = rd0;
            end else begin
                top_cell = s1_data;
            end
            edge_top = top_cell;
            edge_mid = mid_cell;
            edge_bot = bot_cell;
        end else begin
            // Stale line-buffer contents are masked while row is still small.
            mid_cell = (s1_row != '0) ? rd0 : '0;
            top_cell = (s1_row > ONE) ? rd1 : '0;
            edge_top = '0;
            edge_mid = '0;
            edge_bot = '0;
        end
        first_col  = (s1_col == '0);
        win_inside = (s1_row > ONE) && (s1_col > ONE);
    end

    // Stage 2: shift the window left and load the new column; hold otherwise.
    always_ff @(posedge sys_clk) begin
        if (!sys_rst_n) begin
            matrix_de     <= 1'b0;
            matrix_win_ok <= 1'b0;
            matrix_p11    <= '0;
            matrix_p12    <= '0;
            matrix_p13    <= '0;
            matrix_p21    <= '0;
            matrix_p22    <= '0;
            matrix_p23    <= '0;
            matrix_p31    <= '0;
            matrix_p32    <= '0;
            matrix_p33    <= '0;
        end else begin
            matrix_de     <= s1_de;
            matrix_win_ok <= s1_de & win_inside;
            if (s1_de) begin
                matrix_p13 <= top_cell;
                matrix_p23 <= mid_cell;
                matrix_p33 <= bot_cell;
                if (first_col) begin
                    // Columns c-1 and c-2 do not exist at the start of a line.
                    matrix_p11 <= edge_top;
                    matrix_p12 <= edge_top;
                    matrix_p21 <= edge_mid;
                    matrix_p22 <= edge_mid;
                    matrix_p31 <= edge_bot;
                    matrix_p32 <= edge_bot;
                end else begin
                    matrix_p11 <= matrix_p12;
                    matrix_p12 <= matrix_p13;
                    matrix_p21 <= matrix_p22;
                    matrix_p22 <= matrix_p23;
                    matrix_p31 <= matrix_p32;
                    matrix_p32 <= matrix_p33;
                end
            end
        end
    end

endmodule

// File: tb/tb_matrix3x3_gen_param.sv
// Bench for matrix3x3_gen_param on a 4x4 image, pixel = offset + 16*r + c.
// A frame-level image model gives the expected window for each pixel.
`timescale 1ns/1ps
module tb_matrix3x3_gen_param;

    localparam int DATA_W = 8;
    localparam int IMG_W  = 4;
    localparam int IMG_H  = 4;
    localparam int COL_W  = 12;

    logic              sys_clk   = 1'b0;
    logic              sys_rst_n = 1'b0;
    logic              pre_vsync = 1'b0;
    logic              pre_href  = 1'b0;
    logic              pre_de    = 1'b0;
    logic [DATA_W-1:0] pre_data  = '0;
    logic              matrix_vsync;
    logic              matrix_href;
    logic              matrix_de;
    logic              matrix_win_ok;
    logic [DATA_W-1:0] matrix_p11, matrix_p12, matrix_p13;
    logic [DATA_W-1:0] matrix_p21, matrix_p22, matrix_p23;
    logic [DATA_W-1:0] matrix_p31, matrix_p32, matrix_p33;
    logic              line_ovf;

    matrix3x3_gen_param #(
        .DATA_W (DATA_W),
        .IMG_W  (IMG_W),
        .IMG_H  (IMG_H),
        .COL_W  (COL_W)
    ) dut (
        .sys_clk       (sys_clk),
        .sys_rst_n     (sys_rst_n),
        .pre_vsync     (pre_vsync),
        .pre_href      (pre_href),
        .pre_de        (pre_de),
        .pre_data      (pre_data),
        .matrix_vsync  (matrix_vsync),
        .matrix_href   (matrix_href),
        .matrix_de     (matrix_de),
        .matrix_win_ok (matrix_win_ok),
        .matrix_p11    (matrix_p11),
        .matrix_p12    (matrix_p12),
        .matrix_p13    (matrix_p13),
        .matrix_p21    (matrix_p21),
        .matrix_p22    (matrix_p22),
        .matrix_p23    (matrix_p23),
        .matrix_p31    (matrix_p31),
        .matrix_p32    (matrix_p32),
        .matrix_p33    (matrix_p33),
        .line_ovf      (line_ovf)
    );

    always #5 sys_clk = ~sys_clk;

    int cyc = 0;
    always @(posedge sys_clk) cyc <= cyc + 1;

    typedef struct {
        int          due;
        logic [71:0] cells;
        bit          ok;
        int          r;
        int          c;
    } exp_t;

    int          checks   = 0;
    int          failures = 0;
    exp_t        exq[$];
    exp_t        cur_e;
    logic [7:0]  img [0:IMG_H-1][0:IMG_W-1];
    logic [71:0] last_exp = '0;
    bit          vs_log[int];
    bit          hs_log[int];
    bit          chk_en   = 1'b0;
    bit          de_exp;
    int          de_count = 0;
    logic [71:0] cap_win [0:15];
    int          cap_ok  [0:15];
    logic [71:0] dut_cells;

    assign dut_cells = {matrix_p11, matrix_p12, matrix_p13,
                        matrix_p21, matrix_p22, matrix_p23,
                        matrix_p31, matrix_p32, matrix_p33};

    task automatic chk(input string name, input logic [71:0] act, input logic [71:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h want %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Expected window for pixel (r,c) from the frame image, border rule applied.
    function automatic logic [71:0] model_win(input int r, input int c);
        logic [71:0] w;
        w = '0;
        for (int i = 0; i < 3; i++) begin
            for (int j = 0; j < 3; j++) begin
                int rr;
                int cc;
                logic [7:0] v;
                rr = r - (2 - i);
                cc = c - (2 - j);
`ifdef MATRIX_BORDER_REPLICATE_EN
                if (rr < 0) rr = 0;
                if (cc < 0) cc = 0;
                v = img[rr][cc];
`else
                if (rr < 0 || cc < 0) v = 8'h00;
                else v = img[rr][cc];
`endif
                w[8*(8-(3*i+j)) +: 8] = v;
            end
        end
        return w;
    endfunction

    // Drive one input cycle and record what the outputs must show 2 cycles later.
    task automatic step(input bit vs, input bit hs, input bit de, input int r, input int c,
                        input logic [7:0] d);
        exp_t e;
        pre_vsync = vs;
        pre_href  = hs;
        pre_de    = de;
        pre_data  = d;
        if (sys_rst_n) begin
            vs_log[cyc] = vs;
            hs_log[cyc] = hs;
            if (de && c < IMG_W) begin
                img[r][c] = d;
                e.due   = cyc + 2;
                e.cells = model_win(r, c);
                e.ok    = (r >= 2 && c >= 2);
                e.r     = r;
                e.c     = c;
                exq.push_back(e);
            end
        end
        @(posedge sys_clk);
        #1;
    endtask

    task automatic idle(input int n);
        for (int k = 0; k < n; k++) step(1'b0, 1'b0, 1'b0, 0, 0, 8'h00);
    endtask

    // One frame: optional vsync preamble, n_lines lines of n_pix pixels.
    // rst_at = 16*r+c asserts reset together with that pixel and stops the frame.
    task automatic drive_frame(input int n_lines, input int n_pix, input bit gapped,
                               input bit vs_with_de, input int ofs, input int rst_at);
        for (int k = 0; k < 16; k++) begin
            cap_win[k] = '1;
            cap_ok[k]  = -1;
        end
        if (!vs_with_de) begin
            step(1'b1, 1'b0, 1'b0, 0, 0, 8'h00);
            step(1'b1, 1'b0, 1'b0, 0, 0, 8'h00);
        end
        idle(2);
        for (int r = 0; r < n_lines; r++) begin
            for (int c = 0; c < n_pix; c++) begin
                logic [7:0] d;
                d = 8'(ofs + 16 * r + c);
                if (16 * r + c == rst_at) begin
                    chk_en = 1'b0;
                    exq.delete();
                    sys_rst_n = 1'b0;
                    step(1'b0, 1'b1, 1'b1, r, c, d);
                    return;
                end
                step(vs_with_de && r == 0 && c == 0, 1'b1, 1'b1, r, c, d);
                if (gapped) step(1'b0, 1'b1, 1'b0, r, c, d);
            end
            idle(3);
        end
        idle(3);
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, "_de"},     72'(matrix_de),     72'h0);
        chk({tag, "_win_ok"}, 72'(matrix_win_ok), 72'h0);
        chk({tag, "_vsync"},  72'(matrix_vsync),  72'h0);
        chk({tag, "_href"},   72'(matrix_href),   72'h0);
        chk({tag, "_ovf"},    72'(line_ovf),      72'h0);
        chk({tag, "_cells"},  dut_cells,          72'h0);
    endtask

    // Per-cycle comparison against the model.
    always @(negedge sys_clk) begin
        if (chk_en) begin
            de_exp = 1'b0;
            if (exq.size() > 0 && exq[0].due == cyc) begin
                cur_e    = exq.pop_front();
                de_exp   = 1'b1;
                last_exp = cur_e.cells;
            end
            chk("matrix_de", 72'(matrix_de), 72'(de_exp));
            chk("window", dut_cells, last_exp);
            chk("win_ok", 72'(matrix_win_ok), 72'(de_exp && cur_e.ok));
            if (vs_log.exists(cyc - 2)) chk("vsync_delay", 72'(matrix_vsync), 72'(vs_log[cyc - 2]));
            if (hs_log.exists(cyc - 2)) chk("href_delay", 72'(matrix_href), 72'(hs_log[cyc - 2]));
            if (de_exp) begin
                cap_win[cur_e.r * 4 + cur_e.c] = dut_cells;
                cap_ok[cur_e.r * 4 + cur_e.c]  = int'(matrix_win_ok);
            end
            if (matrix_de) de_count++;
        end
    end

    localparam logic [71:0] WIN_22 = 72'h00_01_02_10_11_12_20_21_22;
`ifdef MATRIX_BORDER_REPLICATE_EN
    localparam logic [71:0] WIN_11    = 72'h00_00_01_00_00_01_10_10_11;
    localparam logic [71:0] WIN_00_80 = 72'h80_80_80_80_80_80_80_80_80;
    localparam logic [71:0] WIN_11_80 = 72'h80_80_81_80_80_81_90_90_91;
`else
    localparam logic [71:0] WIN_11    = 72'h00_00_00_00_00_01_00_10_11;
    localparam logic [71:0] WIN_00_80 = 72'h00_00_00_00_00_00_00_00_80;
    localparam logic [71:0] WIN_11_80 = 72'h00_00_00_00_80_81_00_90_91;
`endif

    initial begin
        sys_rst_n = 1'b0;
        repeat (3) @(posedge sys_clk);
        #1;
        chk_all_zero("reset");
        sys_rst_n = 1'b1;
        last_exp  = '0;
        chk_en    = 1'b1;
        idle(2);

        // Continuous frame.
        de_count = 0;
        drive_frame(4, 4, 1'b0, 1'b0, 0, -1);
        chk("cont_win_2_2", cap_win[10], WIN_22);
        chk("cont_ok_2_2", 72'(cap_ok[10]), 72'h1);
        chk("cont_win_1_1", cap_win[5], WIN_11);
        chk("cont_ok_1_1", 72'(cap_ok[5]), 72'h0);
        chk("cont_de_count", 72'(de_count), 72'd16);

        // Gapped pixels; the frame restart coincides with the first pixel.
        de_count = 0;
        drive_frame(4, 4, 1'b1, 1'b1, 0, -1);
        chk("gap_win_2_2", cap_win[10], WIN_22);
        chk("gap_ok_2_2", 72'(cap_ok[10]), 72'h1);
        chk("gap_win_1_1", cap_win[5], WIN_11);
        chk("gap_win_0_0", cap_win[0], 72'h0);
        chk("gap_de_count", 72'(de_count), 72'd16);

        // Overflowing line.
        de_count = 0;
        drive_frame(1, 6, 1'b0, 1'b0, 0, -1);
        chk("ovf_de_count", 72'(de_count), 72'd4);
        chk("ovf_set", 72'(line_ovf), 72'h1);
        step(1'b1, 1'b0, 1'b0, 0, 0, 8'h00);
        chk("ovf_clear", 72'(line_ovf), 72'h0);

        // Reset in the middle of a frame, then a fresh frame with new data.
        drive_frame(4, 4, 1'b0, 1'b0, 0, 2 * 16 + 1);
        chk_all_zero("midrst");
        sys_rst_n = 1'b1;
        vs_log.delete();
        hs_log.delete();
        last_exp = '0;
        chk_en   = 1'b1;
        idle(2);
        drive_frame(4, 4, 1'b0, 1'b0, 8'h80, -1);
        chk("post_rst_win_0_0", cap_win[0], WIN_00_80);
        chk("post_rst_ok_0_0", 72'(cap_ok[0]), 72'h0);
        chk("post_rst_win_1_1", cap_win[5], WIN_11_80);
        chk("post_rst_ok_2_2", 72'(cap_ok[10]), 72'h1);
        idle(4);
        chk("pending_windows", 72'(exq.size()), 72'h0);

        chk_en = 1'b0;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
